ex_muldiv: RTL
==============

# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register. It consumes rs1/rs2 values and funct3 for M-extension instructions and produces a 32-bit result after a fixed number of cycles. While it works, it holds the pipeline through the stall controller. Plain ALU ops bypass it; the EX result mux selects `md_result` when `md_done` is high.

## Interface
- `XLEN`, 32: operand and result width; the shift counter is 6 bits.
- `clk` input 1: pipeline clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `md_start` input 1: ID/EX holds an M-extension op; stays high and stable while stalled.
- `md_funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `md_rs1` input XLEN: operand 1 from ID/EX.
- `md_rs2` input XLEN: operand 2 from ID/EX.
- `md_hold` input 1: downstream stall (`stall[3]`); the EX/MEM register will not accept a result this cycle.
- `md_flush` input 1: branch/jump flush; aborts the operation in flight.
- `md_busy` output 1: state is not IDLE.
- `md_stall_req` output 1: request to the stall controller to freeze IF through ID/EX.
- `md_done` output 1: `md_result` is valid this cycle.
- `md_result` output XLEN: result.

## Operation
- **States:** IDLE, MUL, DIV, DONE. Reset forces IDLE, counter 0, all datapath registers 0. Reset value of all outputs is 0.
- **IDLE, start sampled (`md_start=1`, `md_flush=0`):** latch funct3 and the operand signs. Latch |rs1| and |rs2| for signed variants (MULH both operands, MULHSU rs1 only, DIV/REM both), raw values otherwise.
  - Fast path, divide with `rs2==0`: result is 0xFFFFFFFF for DIV/DIVU and rs1 for REM/REMU. Go to DONE.
  - Fast path, signed overflow (DIV/REM with `rs1==0x80000000`, `rs2==0xFFFFFFFF`): result is 0x80000000 for DIV and 0 for REM. Go to DONE.
  - Otherwise go to MUL (funct3[2]=0) or DIV (funct3[2]=1), counter 0.
- **MUL:** radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, 32 cycles. On the last iteration:
  - Negate the 64-bit product if the effective signs differ.
  - MUL selects bits [31:0]; MULH/MULHSU/MULHU select bits [63:32].
  - Latch `md_result` and go to DONE.
- **DIV:** restoring division, one quotient bit per cycle, 32 cycles. Quotient is negated if sign1^sign2 (DIV). Remainder takes the sign of rs1 (REM). Latch the result and go to DONE.
- **DONE:** `md_done=1`. If `md_hold=0`, go to IDLE next edge. Otherwise stay in DONE with `md_result` stable.
- **Re-trigger guard:** no new start is sampled in the cycle DONE→IDLE. The instruction that just completed has left ID/EX by the next cycle.
- **Outputs:**
  - `md_stall_req = md_start & ~md_done & ~md_flush`.
  - `md_busy = (state != IDLE)`.
  - `md_result` holds its last value outside DONE.
- **Flush:** `md_flush=1` in any state goes to IDLE next edge and clears the counter. No `md_done` is produced. Flush has priority over start and over completion.
- **Mid-operation reset:** asynchronous return to IDLE, outputs 0, partial result discarded.
- **Arithmetic:**
  - Accumulator 64 bits, divisor/remainder 33 bits, no overflow checks inside the iteration.
  - All negations are two's complement at their full width.

## Timing
- Cycle 0 is the first cycle `md_start=1` in IDLE; sampling happens at edge E0.
- Normal MUL/DIV: iterations run at E1..E32 and `md_done=1` in cycle 33. `md_stall_req` is high in cycles 0–32 and low in cycle 33, so ID/EX advances at E33.
- Fast path: `md_done=1` in cycle 1 (stall for cycles 0 only).
- With `md_hold` high in DONE, completion extends one cycle per held cycle. `md_stall_req` stays 0 throughout (the downstream stall already freezes upstream).
- `md_start` deasserting mid-operation without a flush is illegal. The bench asserts that it never happens.
- Back-to-back M ops: the second starts in the cycle after DONE→IDLE, giving a one-cycle bubble.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `md_result`=0xFFFFFFEB, `md_done` in cycle 33, `md_stall_req` high in cycles 0–32.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. All with 33-cycle latency.
- Fast paths:
  - DIV 5/0 → 0xFFFFFFFF in cycle 1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- `md_flush` pulse in cycle 10 of a MUL → IDLE at cycle 11, no `md_done`. A new start in cycle 12 completes correctly in cycle 45.
- `md_hold` high for cycles 33–35 → `md_done` high in cycles 33–36 with `md_result` stable. `rst` low at cycle 20 of a DIV → all outputs 0 immediately and state IDLE.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Handshake and operand bundle between the EX stage and the iterative RV32M unit.
// master = pipeline side, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            md_start;
  logic [2:0]      md_funct3;
  logic [XLEN-1:0] md_rs1;
  logic [XLEN-1:0] md_rs2;
  logic            md_hold;
  logic            md_flush;
  logic            md_busy;
  logic            md_stall_req;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output md_start, md_funct3, md_rs1, md_rs2, md_hold, md_flush,
    input  md_busy, md_stall_req, md_done, md_result
  );

  modport slave (
    input  md_start, md_funct3, md_rs1, md_rs2, md_hold, md_flush,
    output md_busy, md_stall_req, md_done, md_result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [5:0]          cnt_reg, cnt_next;
  logic [2:0]          funct3_reg, funct3_next;
  logic                sign1_reg, sign1_next;
  logic                sign2_reg, sign2_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next;
  logic [XLEN:0]       dvsr_reg, dvsr_next;
  logic [XLEN-1:0]     rem_reg, rem_next;
  logic [XLEN-1:0]     result_reg, result_next;

  // Operand decode for a start in IDLE
  logic            s1_in, s2_in;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_by_zero, div_ovf;

  always_comb begin
    s1_in = 1'b0;
    s2_in = 1'b0;
    case (md.md_funct3)
      3'b001, 3'b100, 3'b110: begin
        s1_in = md.md_rs1[XLEN-1];
        s2_in = md.md_rs2[XLEN-1];
      end
      3'b010:  s1_in = md.md_rs1[XLEN-1];
      default: ;
    endcase
  end

  assign mag1        = s1_in ? -md.md_rs1 : md.md_rs1;
  assign mag2        = s2_in ? -md.md_rs2 : md.md_rs2;
  assign div_by_zero = md.md_funct3[2] && (md.md_rs2 == '0);
  assign div_ovf     = md.md_funct3[2] && !md.md_funct3[0]
                       && (md.md_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                       && (md.md_rs2 == '1);

  // Multiply step: conditionally add multiplicand into the high half, then shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc, mul_prod;

  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? dvsr_reg : '0);
  assign mul_acc  = {mul_sum, acc_reg[XLEN-1:1]};
  assign mul_prod = (sign1_reg ^ sign2_reg) ? -mul_acc : mul_acc;

  // Restoring divide step; diff[XLEN] is a valid borrow because the remainder stays below the divisor
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_rem, div_quo, quo_fix, rem_fix;

  assign div_shift = {rem_reg, acc_reg[XLEN-1]};
  assign div_diff  = div_shift - dvsr_reg;
  assign div_ge    = ~div_diff[XLEN];
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_quo   = {acc_reg[XLEN-2:0], div_ge};
  assign quo_fix   = (sign1_reg ^ sign2_reg) ? -div_quo : div_quo;
  assign rem_fix   = sign1_reg ? -div_rem : div_rem;

  logic last_iter;
  assign last_iter = (cnt_reg == 6'(XLEN - 1));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    funct3_next = funct3_reg;
    sign1_next  = sign1_reg;
    sign2_next  = sign2_reg;
    acc_next    = acc_reg;
    dvsr_next   = dvsr_reg;
    rem_next    = rem_reg;
    result_next = result_reg;

    if (md.md_flush) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (md.md_start) begin
            funct3_next = md.md_funct3;
            sign1_next  = s1_in;
            sign2_next  = s2_in;
            cnt_next    = '0;
            if (div_by_zero) begin
              result_next = md.md_funct3[1] ? md.md_rs1 : '1;
              state_next  = S_DONE;
            end else if (div_ovf) begin
              result_next = md.md_funct3[1] ? '0 : md.md_rs1;
              state_next  = S_DONE;
            end else if (md.md_funct3[2]) begin
              acc_next   = {{XLEN{1'b0}}, mag1};
              dvsr_next  = {1'b0, mag2};
              rem_next   = '0;
              state_next = S_DIV;
            end else begin
              acc_next   = {{XLEN{1'b0}}, mag2};
              dvsr_next  = {1'b0, mag1};
              state_next = S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_next = mul_acc;
          cnt_next = cnt_reg + 6'd1;
          if (last_iter) begin
            result_next = (funct3_reg == 3'b000) ? mul_prod[XLEN-1:0]
                                                 : mul_prod[2*XLEN-1:XLEN];
            cnt_next    = '0;
            state_next  = S_DONE;
          end
        end
        S_DIV: begin
          acc_next = {acc_reg[2*XLEN-1:XLEN], div_quo};
          rem_next = div_rem;
          cnt_next = cnt_reg + 6'd1;
          if (last_iter) begin
            result_next = funct3_reg[1] ? rem_fix : quo_fix;
            cnt_next    = '0;
            state_next  = S_DONE;
          end
        end
        S_DONE: begin
          if (!md.md_hold) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      funct3_reg <= '0;
      sign1_reg  <= 1'b0;
      sign2_reg  <= 1'b0;
      acc_reg    <= '0;
      dvsr_reg   <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      funct3_reg <= funct3_next;
      sign1_reg  <= sign1_next;
      sign2_reg  <= sign2_next;
      acc_reg    <= acc_next;
      dvsr_reg   <= dvsr_next;
      rem_reg    <= rem_next;
      result_reg <= result_next;
    end
  end

  assign md.md_busy      = (state_reg != S_IDLE);
  assign md.md_done      = (state_reg == S_DONE);
  // Gated by reset so every output reads 0 while reset is held, even with md_start high
  assign md.md_stall_req = rst & md.md_start & ~md.md_done & ~md.md_flush;
  assign md.md_result    = result_reg;

endmodule
